// File: rtl/uarc_pkg.sv
// Shared UARC receiver types and width-derivation helpers.
// Entry fields are sized for the widest supported build; narrower builds tie the upper bits to zero.
package uarc_pkg;

    localparam int UARC_MAX_WORD_WIDTH = 64;
    localparam int UARC_MAX_CHAN_BITS  = 8;

    typedef enum logic {
        ST_FREE,
        ST_LOCKED
    } uarc_lock_state_t;

    typedef struct packed {
        logic [UARC_MAX_WORD_WIDTH-1:0] data;
        logic [UARC_MAX_CHAN_BITS-1:0]  channel;
        logic                           stream;
    } uarc_rx_entry_t;

    function automatic int word_width(input int word_mag);
        return 1 << word_mag;
    endfunction

    function automatic int channel_count(input int uarc_sets, input int word_mag);
        return uarc_sets * word_width(word_mag);
    endfunction

endpackage

// File: rtl/uarc_rr_arbiter.sv
// Round-robin arbiter: first request at or after i_start (wrapping), or only
// i_start itself while i_lock is high.
module uarc_rr_arbiter #(
    parameter  int N  = 32,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    input  logic          i_lock,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_index,
    output logic          o_valid
);

    always_comb begin
        int            j;
        logic [IW-1:0] w_idx;
        j       = 0;
        w_idx   = '0;
        o_grant = '0;
        o_index = '0;
        o_valid = 1'b0;
        if (i_lock) begin
            if (i_req[i_start]) begin
                o_valid          = 1'b1;
                o_index          = i_start;
                o_grant[i_start] = 1'b1;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                j = int'(i_start) + i;
                if (j >= N) j = j - N;
                w_idx = IW'(j);
                if (!o_valid && i_req[w_idx]) begin
                    o_valid        = 1'b1;
                    o_index        = w_idx;
                    o_grant[w_idx] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uarc_receiver.sv
// UARC receiver front end: arbitrates kills, sends and streams across all
// channels and queues accepted words in a show-ahead FIFO.
module uarc_receiver
    import uarc_pkg::*;
#(
    parameter  int WORD_MAG   = 5,
    parameter  int UARC_SETS  = 1,
    parameter  int FIFO_MAG   = 2,
    localparam int WORD_WIDTH = word_width(WORD_MAG),
    localparam int CHANNELS   = channel_count(UARC_SETS, WORD_MAG),
    localparam int CH_W       = $clog2(CHANNELS),
    localparam int DEPTH      = 1 << FIFO_MAG
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [CHANNELS-1:0]                 receiver_enable,
    input  logic [CHANNELS-1:0]                 receiver_kills,
    output logic [CHANNELS-1:0]                 receiver_kill_acks,
    input  logic [CHANNELS-1:0]                 receiver_sends,
    output logic [CHANNELS-1:0]                 receiver_send_acks,
    input  logic [CHANNELS-1:0]                 receiver_streams,
    output logic [CHANNELS-1:0]                 receiver_stream_acks,
    input  logic [CHANNELS-1:0][WORD_WIDTH-1:0] receiver_datas,
    output logic                                msg_valid,
    input  logic                                msg_ready,
    output logic [WORD_WIDTH-1:0]               msg_data,
    output logic [CH_W-1:0]                     msg_channel,
    output logic                                msg_stream,
    output logic                                kill_valid,
    output logic [CH_W-1:0]                     kill_channel
);

    function automatic logic [CH_W-1:0] next_chan(input logic [CH_W-1:0] c);
        return (int'(c) == CHANNELS - 1) ? '0 : c + CH_W'(1);
    endfunction

    uarc_lock_state_t r_state, w_state_next;
    logic [CH_W-1:0]     r_rr, w_rr_next;
    logic [CH_W-1:0]     r_lock_ch, w_lock_ch_next;
    logic                r_kill_valid;
    logic [CH_W-1:0]     r_kill_channel;

    uarc_rx_entry_t      r_mem [DEPTH];
    logic [FIFO_MAG-1:0] r_wr, r_rd;
    logic [FIFO_MAG:0]   r_count;

    logic [CHANNELS-1:0] w_kill_req, w_kill_ack_oh, w_data_req, w_arb_grant, w_grant_oh;
    logic                w_kill_any, w_arb_valid, w_grant_en, w_push, w_pop, w_full;
    logic                w_lock_active, w_lock_killed, w_grant_stream;
    logic [CH_W-1:0]     w_kill_idx, w_arb_start, w_arb_index;
    uarc_rx_entry_t      w_push_entry;

    // A kill ack masks that channel's data request in the same cycle.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign w_kill_req[gi]           = receiver_enable[gi] & receiver_kills[gi];
        assign w_data_req[gi]           = receiver_enable[gi] & (receiver_sends[gi] | receiver_streams[gi])
                                          & ~w_kill_ack_oh[gi];
        assign w_grant_oh[gi]           = w_arb_grant[gi] & w_grant_en;
        assign receiver_stream_acks[gi] = w_grant_oh[gi] & receiver_streams[gi];
        assign receiver_send_acks[gi]   = w_grant_oh[gi] & ~receiver_streams[gi];
    end

    assign receiver_kill_acks = w_kill_ack_oh;

    always_comb begin
        w_kill_any    = 1'b0;
        w_kill_idx    = '0;
        w_kill_ack_oh = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_kill_req[CH_W'(i)] && !reset) begin
                w_kill_any = 1'b1;
                w_kill_idx = CH_W'(i);
            end
        end
        if (w_kill_any) w_kill_ack_oh[w_kill_idx] = 1'b1;
    end

    // The lock only holds while the owner keeps streaming and stays enabled.
    assign w_lock_active  = (r_state == ST_LOCKED) && receiver_enable[r_lock_ch] && receiver_streams[r_lock_ch];
    assign w_lock_killed  = w_lock_active && w_kill_any && (w_kill_idx == r_lock_ch);
    assign w_arb_start    = w_lock_active ? r_lock_ch : r_rr;
    assign w_full         = (r_count == (FIFO_MAG+1)'(DEPTH));
    assign w_grant_en     = !reset && !w_full;
    assign w_push         = w_arb_valid && w_grant_en;
    assign w_pop          = msg_valid && msg_ready;
    assign w_grant_stream = receiver_streams[w_arb_index];

    uarc_rr_arbiter #(.N(CHANNELS)) u_arb (
        .i_req   (w_data_req),
        .i_start (w_arb_start),
        .i_lock  (w_lock_active),
        .o_grant (w_arb_grant),
        .o_index (w_arb_index),
        .o_valid (w_arb_valid)
    );

    always_comb begin
        w_state_next   = r_state;
        w_lock_ch_next = r_lock_ch;
        w_rr_next      = r_rr;
        if (r_state == ST_LOCKED && (!w_lock_active || w_lock_killed)) begin
            w_state_next = ST_FREE;
            w_rr_next    = next_chan(r_lock_ch);
        end
        if (w_push) begin
            if (w_grant_stream) begin
                w_state_next   = ST_LOCKED;
                w_lock_ch_next = w_arb_index;
            end else begin
                w_rr_next = next_chan(w_arb_index);
            end
        end
    end

    always_comb begin
        w_push_entry                         = '0;
        w_push_entry.data[WORD_WIDTH-1:0]    = receiver_datas[w_arb_index];
        w_push_entry.channel[CH_W-1:0]       = w_arb_index;
        w_push_entry.stream                  = w_grant_stream;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_FREE;
            r_rr           <= '0;
            r_lock_ch      <= '0;
            r_kill_valid   <= 1'b0;
            r_kill_channel <= '0;
            r_wr           <= '0;
            r_rd           <= '0;
            r_count        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_rr         <= w_rr_next;
            r_lock_ch    <= w_lock_ch_next;
            r_kill_valid <= w_kill_any;
            if (w_kill_any) r_kill_channel <= w_kill_idx;
            if (w_push) r_wr <= r_wr + FIFO_MAG'(1);
            if (w_pop)  r_rd <= r_rd + FIFO_MAG'(1);
            r_count <= r_count + (FIFO_MAG+1)'(w_push) - (FIFO_MAG+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= w_push_entry;
    end

    assign msg_valid    = (r_count != '0);
    assign msg_data     = r_mem[r_rd].data[WORD_WIDTH-1:0];
    assign msg_channel  = r_mem[r_rd].channel[CH_W-1:0];
    assign msg_stream   = r_mem[r_rd].stream;
    assign kill_valid   = r_kill_valid;
    assign kill_channel = r_kill_channel;

endmodule

// File: doc/uarc_receiver.md
# uarc_receiver

Receiver-side front end for a UARC core, generalised over any number of UARC sets. Arbitrates the per-bus receiver send, stream and kill requests, acknowledges them on the bus, and queues accepted words with their source channel in a parametrised FIFO for the core pipeline. Kills bypass the FIFO as a prioritised one-cycle event. Sits between the UARC bus receiver ports and the core's message-dispatch logic.

## Interface
- WORD_MAG, 5, log2 of word width; WORD_WIDTH = 1 << WORD_MAG
- UARC_SETS, 1, bus sets; CHANNELS = UARC_SETS * WORD_WIDTH
- FIFO_MAG, 2, log2 of FIFO depth; DEPTH = 1 << FIFO_MAG
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- receiver_enable  in  CHANNELS  channel has a connected sender
- receiver_kills  in  CHANNELS  kill request, level, held until acked
- receiver_kill_acks  out  CHANNELS  kill acknowledge, one-hot, combinational
- receiver_sends  in  CHANNELS  single-word send request, level
- receiver_send_acks  out  CHANNELS  send acknowledge, one-hot, combinational
- receiver_streams  in  CHANNELS  stream request, held for whole stream
- receiver_stream_acks  out  CHANNELS  per-word stream acknowledge, one-hot, combinational
- receiver_datas  in  [CHANNELS][WORD_WIDTH]  per-channel data
- msg_valid  out  1  FIFO head valid
- msg_ready  in  1  consumer pops head when msg_valid && msg_ready
- msg_data  out  WORD_WIDTH  head word
- msg_channel  out  $clog2(CHANNELS)  head source channel
- msg_stream  out  1  head came from a stream
- kill_valid  out  1  registered one-cycle kill event
- kill_channel  out  $clog2(CHANNELS)  channel of kill event

## Operation
- A channel is eligible only when receiver_enable is high. Requests on disabled channels are ignored and never acked.
- Kill arbitration: fixed priority, lowest eligible index. At most one kill ack per cycle, regardless of FIFO state. Edge after ack: kill_valid=1, kill_channel=index. Other kills wait.
- Kill on the locked stream channel releases the lock at that edge. A stream word requested by that channel in the same cycle is not acked.
- Data arbitration is round-robin over eligible channels with send or stream high. Search starts at pointer rr, ascending, wrapping from CHANNELS-1 to 0. Grant only when FIFO not full (count < DEPTH); a pop in the same cycle does not relax this.
- A channel cannot receive a data grant in a cycle it receives a kill ack.
- Grant to channel g: assert send_ack[g] (or stream_ack[g] if streams[g]; stream wins if both high). Push {receiver_datas[g], g, stream flag} at the edge.
- Send grant: rr <= (g+1) mod CHANNELS.
- Stream grant: lock <= g. While locked, only g is considered. One word is acked per cycle while FIFO not full. rr is unchanged.
- Lock releases in the first cycle receiver_streams[g] is low, or receiver_enable[g] is low; that cycle's arbitration is then normal. rr <= (g+1) mod CHANNELS on release.
- FIFO: show-ahead; msg_* reflect head combinationally from storage. Push and pop in the same cycle are both honoured. count is FIFO_MAG+1 bits; read and write pointers are FIFO_MAG bits and wrap naturally.

## Timing
- Acks are combinational from requests and state, same cycle; sender drops or advances the request after the edge. Data is captured at that edge.
- Latency from ack to msg_valid is 1 cycle into an empty FIFO.
- Latency from kill ack to kill_valid is 1 cycle.
- Throughput is 1 word per cycle.
- Reset (synchronous): while reset is high, all acks = 0.
- Reset values: count=0, pointers=0, rr=0, lock released, kill_valid=0, kill_channel=0, msg_valid=0. msg_data, msg_channel and msg_stream are don't-care.
- Reset mid-stream or with the FIFO full discards all contents; no ack is issued in the reset cycle.

## Structure
- Package uarc_pkg: WORD_WIDTH/CHANNELS derivation functions and the uarc_rx_entry_t struct {data, channel, stream}. Shared with core0 successors.
- Sub-module uarc_rr_arbiter (parameter N): inputs request vector, start pointer and lock; outputs one-hot grant and encoded index. It is reused for the sender side later.
- FIFO storage is inline: an array of uarc_rx_entry_t.

## Test plan
- Sends on channels 3 and 7 in the same cycle, rr=0: ack 3 first, then 7; FIFO outputs channel 3 then channel 7; rr ends at 8.
- Channel 5 streams 6 words, DEPTH=4, msg_ready low: 4 acks, then acks stall; channel 2's send is never acked during the lock. Pop one entry: the 5th word is acked next cycle.
- Channel 5 stream locked, kill from channel 5 arrives: kill_ack[5] asserted, no stream_ack that cycle, kill_valid=1/kill_channel=5 the next cycle, lock released.
- Kills on channels 1 and 4 simultaneously with a send on 9: kill_ack[1] and send_ack[9] in the same cycle; kill_ack[4] the next cycle.
- Send on a channel with receiver_enable=0: no ack, FIFO stays empty. Round-robin wrap with UARC_SETS=2: send on 63 with rr=63, then send on 0 acked next.
- Reset asserted with 3 entries queued and a stream locked: acks 0 during reset; afterwards msg_valid=0, count=0, lock cleared.
